// File: rtl/ped_crossing_scheduler.sv
// ped_crossing_scheduler: round-robin sequencer for pedestrian crossing starts across N channels.
// Define PED_SCHED_TIMEOUT_EN to abandon grants that are not acknowledged within ACK_TIMEOUT cycles.
module ped_crossing_scheduler #(
    parameter int N           = 4,
    parameter int GAP_CYCLES  = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         busy,
    output logic [N-1:0]         start,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [N-1:0]         pending,
    output logic                 timeout
);
    localparam int W = $clog2(N);

    if (N < 2 || N > 16 || GAP_CYCLES < 0 || GAP_CYCLES > 255 || ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255)
        $error("ped_crossing_scheduler: parameter out of range");

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    state_t         state, nxt;
    logic [N-1:0]   req_q, rise, clr;
    logic [W-1:0]   ptr, pick, cand;
    logic [7:0]     gcnt;
    logic           found, grant, ack, expire;

    assign rise  = req & ~req_q;
    assign start = (state == START) ? N'(1) << grant_id : '0;
    assign clr   = (ack || expire) ? N'(1) << grant_id : '0;

    // First pending channel after the last grant, wrapping at N-1.
    always_comb begin
        pick  = ptr;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!found && pending[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef PED_SCHED_TIMEOUT_EN
    logic [7:0] tcnt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            tcnt    <= (state == START) ? tcnt + 8'd1 : '0;
            timeout <= expire;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        nxt    = state;
        grant  = 1'b0;
        ack    = 1'b0;
        expire = 1'b0;
        case (state)
            IDLE:
                if (|pending) begin
                    grant = 1'b1;
                    nxt   = START;
                end
            START:
                if (busy[grant_id]) begin
                    ack = 1'b1;
                    nxt = WAIT_DONE;
                end
`ifdef PED_SCHED_TIMEOUT_EN
                else if (tcnt == 8'(ACK_TIMEOUT - 1)) begin
                    expire = 1'b1;
                    nxt    = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
`endif
            WAIT_DONE:
                if (!busy[grant_id]) nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:
                if (gcnt == 8'd1) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            req_q    <= '0;
            pending  <= '0;
            ptr      <= W'(N - 1);
            grant_id <= '0;
            gcnt     <= '0;
        end else begin
            state   <= nxt;
            req_q   <= req;
            pending <= (pending & ~clr) | rise;
            if (grant) begin
                grant_id <= pick;
                ptr      <= pick;
            end
            if (state != GAP && nxt == GAP) gcnt <= 8'(GAP_CYCLES);
            else if (state == GAP) gcnt <= gcnt - 8'd1;
        end
    end
endmodule
